// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 memory responder.
package axi_mem_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Next word index for a burst plus a flag for bursts that are legal as issued.
module axi_mem_addr_gen
   import axi_mem_pkg::*;
#(
   parameter int unsigned IDX_W = 10
)(
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       len,
   input  burst_t           burst,
   output logic [IDX_W-1:0] next_idx_c,
   output logic             legal_c
);

   logic [IDX_W-1:0] wrap_mask;
   logic [IDX_W-1:0] idx_inc;

   assign wrap_mask = IDX_W'(len[3:0]);
   assign idx_inc   = idx + IDX_W'(1);

   // Illegal bursts fall back to INCR ordering; the caller reports SLVERR.
   always_comb begin
      legal_c    = 1'b1;
      next_idx_c = idx_inc;
      case (burst)
         BURST_FIXED: next_idx_c = idx;
         BURST_INCR:  next_idx_c = idx_inc;
         BURST_WRAP: begin
            if (wrap_len_ok(len)) next_idx_c = (idx & ~wrap_mask) | (idx_inc & wrap_mask);
            else                  legal_c    = 1'b0;
         end
         default:     legal_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a word RAM; independent single-outstanding write and read engines.
// Optional out-of-range DECERR checking is enabled by defining AXI_MEM_RESP_DECERR_EN.
module axi_mem_responder
   import axi_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 1024
)(
   input  logic                aclk,
   input  logic                areset,
   input  logic [ADDR_W-1:0]   s_awaddr,
   input  logic [7:0]          s_awlen,
   input  logic [1:0]          s_awburst,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wlast,
   input  logic                s_wvalid,
   output logic                s_wready,
   output logic [1:0]          s_bresp,
   output logic                s_bvalid,
   input  logic                s_bready,
   input  logic [ADDR_W-1:0]   s_araddr,
   input  logic [7:0]          s_arlen,
   input  logic [1:0]          s_arburst,
   input  logic                s_arvalid,
   output logic                s_arready,
   output logic [DATA_W-1:0]   s_rdata,
   output logic [1:0]          s_rresp,
   output logic                s_rlast,
   output logic                s_rvalid,
   input  logic                s_rready
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [IDX_W-1:0] aw_idx_c, ar_idx_c;
   logic             aw_oob_c, ar_oob_c;
   logic             unused_c;

   assign aw_idx_c = s_awaddr[OFF_W +: IDX_W];
   assign ar_idx_c = s_araddr[OFF_W +: IDX_W];
   assign unused_c = ^{s_awaddr, s_araddr};

`ifdef AXI_MEM_RESP_DECERR_EN
   localparam int unsigned FULL_W = ADDR_W - OFF_W;

   // Highest beat index of the burst without modulo wrapping.
   function automatic logic beat_oob(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                     input logic [1:0] burst);
      logic [FULL_W:0] base;
      logic [FULL_W:0] span;
      logic [FULL_W:0] hi;
      base = {1'b0, addr[ADDR_W-1:OFF_W]};
      span = (FULL_W+1)'(len);
      case (burst)
         BURST_FIXED: hi = base;
         BURST_WRAP:  hi = wrap_len_ok(len) ? ((base & ~span) + span) : (base + span);
         default:     hi = base + span;
      endcase
      return hi >= (FULL_W+1)'(DEPTH);
   endfunction

   assign aw_oob_c = beat_oob(s_awaddr, s_awlen, s_awburst);
   assign ar_oob_c = beat_oob(s_araddr, s_arlen, s_arburst);
`else
   assign aw_oob_c = 1'b0;
   assign ar_oob_c = 1'b0;
`endif

   // ---------------- write engine ----------------
   wr_state_t        wr_state_q, wr_state_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d, wr_next_idx_c;
   logic [7:0]       wr_len_q, wr_len_d, wr_beat_q, wr_beat_d;
   burst_t           wr_burst_q, wr_burst_d;
   logic             wr_err_q, wr_err_d, wr_dec_q, wr_dec_d, wr_legal_c;
   logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]       bresp_q, bresp_d;
   logic             aw_hs_c, w_hs_c, wr_last_c, wr_en_c;

   axi_mem_addr_gen #(.IDX_W(IDX_W)) u_wr_gen (
      .idx        (wr_idx_q),
      .len        (wr_len_q),
      .burst      (wr_burst_q),
      .next_idx_c (wr_next_idx_c),
      .legal_c    (wr_legal_c)
   );

   assign aw_hs_c   = s_awvalid & awready_q;
   assign w_hs_c    = s_wvalid & wready_q;
   assign wr_last_c = (wr_beat_q == wr_len_q);

   always_comb begin
      wr_state_d = wr_state_q;
      wr_idx_d   = wr_idx_q;
      wr_len_d   = wr_len_q;
      wr_beat_d  = wr_beat_q;
      wr_burst_d = wr_burst_q;
      wr_err_d   = wr_err_q;
      wr_dec_d   = wr_dec_q;
      bresp_d    = bresp_q;
      wr_en_c    = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (aw_hs_c) begin
               wr_state_d = WR_DATA;
               wr_idx_d   = aw_idx_c;
               wr_len_d   = s_awlen;
               wr_burst_d = burst_t'(s_awburst);
               wr_beat_d  = 8'd0;
               wr_err_d   = 1'b0;
               wr_dec_d   = aw_oob_c;
            end
         end
         WR_DATA: begin
            if (w_hs_c) begin
               wr_en_c   = ~wr_dec_q;
               wr_idx_d  = wr_next_idx_c;
               wr_beat_d = wr_beat_q + 8'd1;
               if (wr_last_c) begin
                  wr_state_d = WR_RESP;
                  if (wr_dec_q)                                  bresp_d = RESP_DECERR;
                  else if (!wr_legal_c || wr_err_q || !s_wlast)  bresp_d = RESP_SLVERR;
                  else                                           bresp_d = RESP_OKAY;
               end else if (s_wlast) begin
                  wr_err_d = 1'b1;
               end
            end
         end
         WR_RESP: begin
            if (s_bready && bvalid_q) begin
               wr_state_d = WR_IDLE;
               bresp_d    = RESP_OKAY;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
      awready_d = (wr_state_d == WR_IDLE);
      wready_d  = (wr_state_d == WR_DATA);
      bvalid_d  = (wr_state_d == WR_RESP);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_state_q <= WR_IDLE;
         wr_idx_q   <= '0;
         wr_len_q   <= 8'd0;
         wr_beat_q  <= 8'd0;
         wr_burst_q <= BURST_FIXED;
         wr_err_q   <= 1'b0;
         wr_dec_q   <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         wr_idx_q   <= wr_idx_d;
         wr_len_q   <= wr_len_d;
         wr_beat_q  <= wr_beat_d;
         wr_burst_q <= wr_burst_d;
         wr_err_q   <= wr_err_d;
         wr_dec_q   <= wr_dec_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge aclk) begin
      if (wr_en_c) begin
         for (int b = 0; b < int'(STRB_W); b++) begin
            if (s_wstrb[b]) mem_q[wr_idx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   rd_state_t         rd_state_q, rd_state_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d, rd_next_idx_c, rd_fetch_idx_c;
   logic [7:0]        rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
   burst_t            rd_burst_q, rd_burst_d;
   logic              rd_dec_q, rd_dec_d, rd_legal_c, rd_fetch_c, ar_hs_c;
   logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   axi_mem_addr_gen #(.IDX_W(IDX_W)) u_rd_gen (
      .idx        (rd_idx_q),
      .len        (rd_len_q),
      .burst      (rd_burst_q),
      .next_idx_c (rd_next_idx_c),
      .legal_c    (rd_legal_c)
   );

   assign ar_hs_c = s_arvalid & arready_q;

   // The output register doubles as the RAM read register, so a write on the
   // same edge to the fetched word is not yet visible (read-first).
   always_comb begin
      rd_state_d     = rd_state_q;
      rd_idx_d       = rd_idx_q;
      rd_len_d       = rd_len_q;
      rd_beat_d      = rd_beat_q;
      rd_burst_d     = rd_burst_q;
      rd_dec_d       = rd_dec_q;
      rlast_d        = rlast_q;
      rresp_d        = rresp_q;
      rdata_d        = rdata_q;
      rd_fetch_c     = 1'b0;
      rd_fetch_idx_c = rd_idx_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (ar_hs_c) begin
               rd_state_d = RD_DATA;
               rd_idx_d   = ar_idx_c;
               rd_len_d   = s_arlen;
               rd_burst_d = burst_t'(s_arburst);
               rd_beat_d  = 8'd0;
               rd_dec_d   = ar_oob_c;
            end
         end
         RD_DATA: begin
            if (!rvalid_q) begin
               rd_fetch_c = 1'b1;
               rlast_d    = (rd_beat_q == rd_len_q);
            end else if (s_rready) begin
               if (rlast_q) begin
                  rd_state_d = RD_IDLE;
                  rlast_d    = 1'b0;
               end else begin
                  rd_fetch_c     = 1'b1;
                  rd_fetch_idx_c = rd_next_idx_c;
                  rd_idx_d       = rd_next_idx_c;
                  rd_beat_d      = rd_beat_q + 8'd1;
                  rlast_d        = ((rd_beat_q + 8'd1) == rd_len_q);
               end
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
      if (rd_fetch_c) begin
         rdata_d = rd_dec_q ? '0 : mem_q[rd_fetch_idx_c];
         rresp_d = rd_dec_q ? RESP_DECERR : (rd_legal_c ? RESP_OKAY : RESP_SLVERR);
      end
      arready_d = (rd_state_d == RD_IDLE);
      rvalid_d  = (rd_state_d == RD_DATA) && (rvalid_q || rd_fetch_c);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rd_state_q <= RD_IDLE;
         rd_idx_q   <= '0;
         rd_len_q   <= 8'd0;
         rd_beat_q  <= 8'd0;
         rd_burst_q <= BURST_FIXED;
         rd_dec_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_idx_q   <= rd_idx_d;
         rd_len_q   <= rd_len_d;
         rd_beat_q  <= rd_beat_d;
         rd_burst_q <= rd_burst_d;
         rd_dec_q   <= rd_dec_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rlast_q    <= rlast_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;
   assign s_arready = arready_q;
   assign s_rvalid  = rvalid_q;
   assign s_rlast   = rlast_q;
   assign s_rresp   = rresp_q;
   assign s_rdata   = rdata_q;

endmodule
